lcd_status_fmt: RTL and testbench

LCD_STATUS_FMT -- requirements
Module: lcd_status_fmt

---
 rtl/lcd_status_fmt_pkg.sv | 29 ++
 rtl/lcd_status_fmt_bin2bcd_seq.sv | 60 ++++++
 rtl/lcd_status_fmt.sv | 147 ++++++++++++++
 tb/tb_lcd_status_fmt.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_status_fmt_pkg.sv
// Shared types and constants for the LCD status formatter.
// Optional feature macro: LCD_FMT_ZERO_SUPPRESS_EN (blank leading score zeros).
package lcd_status_fmt_pkg;

    // Refresh sequencer states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_CONVERT = 2'd2,
        ST_PACK    = 2'd3
    } fmt_state_e;

    // Row contents shown until the first refresh completes
    localparam logic [127:0] ROW_INIT   = {16{8'h3F}};

    // Fixed text fragments
    localparam logic [47:0]  STR_TETRIS = "TETRIS";
    localparam logic [39:0]  STR_SCORE  = "SCORE";

    // Number of double-dabble iterations (one per input bit)
    localparam int unsigned  CONV_STEPS = 16;

    // Nibble to uppercase ASCII hex digit
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        else           return 8'h41 + {4'h0, n} - 8'd10;
    endfunction

endpackage

// File: rtl/lcd_status_fmt_bin2bcd_seq.sv
// Sequential 16-bit binary to 5-digit BCD converter (shift-add-3).
// start latches the operand; exactly 16 iterations follow, then done pulses
// for one cycle while bcd holds the result.
module bin2bcd_seq
    import lcd_status_fmt_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [15:0] bin_i,
    output logic        done_o,
    output logic [19:0] bcd_o
);

    logic [15:0] sh_q;
    logic [19:0] bcd_q;
    logic [19:0] bcd_adj;
    logic [3:0]  it_q;
    logic        run_q;
    logic        done_q;

    // Add 3 to every BCD digit that is 5 or more before the next shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 5; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // Load on start, then shift one binary bit into the BCD field per cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q   <= '0;
            bcd_q  <= '0;
            it_q   <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                sh_q  <= bin_i;
                bcd_q <= '0;
                it_q  <= '0;
                run_q <= 1'b1;
            end else if (run_q) begin
                {bcd_q, sh_q} <= {bcd_adj[18:0], sh_q, 1'b0};
                it_q          <= it_q + 4'd1;
                if (it_q == 4'(CONV_STEPS - 1)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done_o = done_q;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/lcd_status_fmt.sv
// LCD status formatter: every REFRESH_CYCLES clocks it snapshots the tetris
// state, last command and score, converts the score to decimal and packs two
// 16-character ASCII rows. Define LCD_FMT_ZERO_SUPPRESS_EN to blank leading
// score zeros (the last digit is always shown).
module lcd_status_fmt
    import lcd_status_fmt_pkg::*;
#(
    parameter int REFRESH_CYCLES = 500000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   state_code,
    input  logic [7:0]   ctrl_code,
    input  logic [15:0]  score,
    output logic [127:0] row_A,
    output logic [127:0] row_B,
    output logic         busy,
    output logic         update
);

    localparam int              CW       = $clog2(REFRESH_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(REFRESH_CYCLES - 1);

    fmt_state_e   state_q;
    logic [CW-1:0] cnt_q;
    logic         tick;
    logic [7:0]   last_cmd_q;
    logic [7:0]   snap_state_q;
    logic [7:0]   snap_cmd_q;
    logic [3:0]   conv_cnt_q;
    logic [127:0] row_a_q;
    logic [127:0] row_b_q;
    logic         busy_q;
    logic         update_q;
    logic         conv_start;
    logic         conv_done;
    logic [19:0]  conv_bcd;

    // Score digits as ASCII, most significant digit in the top byte
    function automatic logic [39:0] fmt_score(input logic [19:0] bcd);
        logic [39:0] s;
`ifdef LCD_FMT_ZERO_SUPPRESS_EN
        logic lead;
        lead = 1'b1;
`endif
        s = '0;
        for (int i = 4; i >= 0; i--) begin
`ifdef LCD_FMT_ZERO_SUPPRESS_EN
            if (lead && (i != 0) && (bcd[4*i +: 4] == 4'd0)) begin
                s[8*i +: 8] = 8'h20;
            end else begin
                lead        = 1'b0;
                s[8*i +: 8] = 8'h30 + {4'h0, bcd[4*i +: 4]};
            end
`else
            s[8*i +: 8] = 8'h30 + {4'h0, bcd[4*i +: 4]};
`endif
        end
        return s;
    endfunction

    assign tick = (cnt_q == CNT_LAST);

    // Free-running refresh counter; keeps counting while a refresh is busy
    always_ff @(posedge clk) begin
        if (reset)     cnt_q <= '0;
        else if (tick) cnt_q <= '0;
        else           cnt_q <= cnt_q + 1'b1;
    end

    // Remember the most recent non-NONE control command
    always_ff @(posedge clk) begin
        if (reset)                  last_cmd_q <= '0;
        else if (ctrl_code != 8'd0) last_cmd_q <= ctrl_code;
    end

    // The converter latches score on the CAPTURE edge, so later score
    // changes cannot leak into the refresh in flight.
    assign conv_start = (state_q == ST_CAPTURE);

    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .reset   (reset),
        .start_i (conv_start),
        .bin_i   (score),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    // Refresh sequencer with registered busy/update/rows
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            snap_state_q <= '0;
            snap_cmd_q   <= '0;
            conv_cnt_q   <= '0;
            row_a_q      <= ROW_INIT;
            row_b_q      <= ROW_INIT;
            busy_q       <= 1'b0;
            update_q     <= 1'b0;
        end else begin
            update_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (tick) begin
                        state_q <= ST_CAPTURE;
                        busy_q  <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    snap_state_q <= state_code;
                    snap_cmd_q   <= last_cmd_q;
                    conv_cnt_q   <= '0;
                    state_q      <= ST_CONVERT;
                end
                ST_CONVERT: begin
                    conv_cnt_q <= conv_cnt_q + 4'd1;
                    if (conv_cnt_q == 4'(CONV_STEPS - 1))
                        state_q <= ST_PACK;
                end
                ST_PACK: begin
                    if (conv_done) begin
                        row_a_q  <= {"S:", hex_char(snap_state_q[7:4]),
                                     hex_char(snap_state_q[3:0]),
                                     "  ", STR_TETRIS, "    "};
                        row_b_q  <= {"C:", hex_char(snap_cmd_q[7:4]),
                                     hex_char(snap_cmd_q[3:0]),
                                     " ", STR_SCORE, " ", fmt_score(conv_bcd)};
                        update_q <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign row_A  = row_a_q;
    assign row_B  = row_b_q;
    assign busy   = busy_q;
    assign update = update_q;

endmodule

// File: tb/tb_lcd_status_fmt.sv
// Bench for lcd_status_fmt with REFRESH_CYCLES=32: directed refreshes with
// literal expected rows, a mid-refresh reset, then randomized refreshes.
// A cycle model pushes expected rows at each PACK; a monitor pops them.
module tb_lcd_status_fmt;

    localparam int R = 32;
    localparam logic [127:0] INIT_ROW = {16{8'h3F}};

    logic         clk;
    logic         reset;
    logic [7:0]   state_code;
    logic [7:0]   ctrl_code;
    logic [15:0]  score;
    logic [127:0] row_A;
    logic [127:0] row_B;
    logic         busy;
    logic         update;

    lcd_status_fmt #(.REFRESH_CYCLES(R)) dut (
        .clk        (clk),
        .reset      (reset),
        .state_code (state_code),
        .ctrl_code  (ctrl_code),
        .score      (score),
        .row_A      (row_A),
        .row_B      (row_B),
        .busy       (busy),
        .update     (update)
    );

    typedef struct {
        logic [127:0] a;
        logic [127:0] b;
    } exp_t;

    exp_t sbq[$];

    int nvec = 0;
    int nerr = 0;

    // model state
    int           mcnt = 0;
    int           mph  = 0;
    int           mlast = 0;
    int           ss = 0, sc = 0, sv = 0;
    int           m_ticks = 0;
    logic         m_upd  = 1'b0;
    logic         m_busy = 1'b0;
    logic [127:0] mrowA  = INIT_ROW;
    logic [127:0] mrowB  = INIT_ROW;

    int   upd_cnt  = 0;
    logic prev_upd = 1'b0;
    logic rnd_on   = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr + 1);
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] tb_hex(input int n);
        return (n < 10) ? 8'(48 + n) : 8'(55 + n);
    endfunction

    function automatic logic [127:0] exp_a(input int st);
        logic [127:0] r;
        r = "S:??  TETRIS    ";
        r[111:104] = tb_hex((st >> 4) & 15);
        r[103:96]  = tb_hex(st & 15);
        return r;
    endfunction

    function automatic logic [127:0] exp_b(input int cmd, input int val);
        logic [127:0] r;
        int pw;
        int d;
        bit lead;
        r = "C:?? SCORE ?????";
        r[111:104] = tb_hex((cmd >> 4) & 15);
        r[103:96]  = tb_hex(cmd & 15);
        pw   = 10000;
        lead = 1'b1;
        for (int j = 0; j < 5; j++) begin
            d = (val / pw) % 10;
            pw = pw / 10;
`ifdef LCD_FMT_ZERO_SUPPRESS_EN
            if (lead && d == 0 && j != 4) begin
                r[127 - 8*(11+j) -: 8] = 8'h20;
            end else begin
                lead = 1'b0;
                r[127 - 8*(11+j) -: 8] = 8'(48 + d);
            end
`else
            r[127 - 8*(11+j) -: 8] = 8'(48 + d);
`endif
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_upd(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!update && n < 100);
        nvec++;
        if (!update) begin
            nerr++;
            $display("FAIL %s_timeout: got no update in %0d cycles expected update", nm, n);
        end
    endtask

    task automatic wait_busy(input string nm);
        int n;
        n = 0;
        while (!busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        nvec++;
        if (!busy) begin
            nerr++;
            $display("FAIL %s_timeout: got busy=0 after %0d cycles expected busy=1", nm, n);
        end
    endtask

    // Cycle model of the refresh timing, evaluated on the DUT's sampling edge
    initial begin
        bit tk;
        forever begin
            @(posedge clk);
            m_upd = 1'b0;
            if (reset) begin
                mcnt  = 0;
                mlast = 0;
                mph   = 0;
                mrowA = INIT_ROW;
                mrowB = INIT_ROW;
            end else begin
                tk = (mcnt == R - 1);
                if (tk) m_ticks++;
                if (mph == 0) begin
                    if (tk) mph = 1;
                end else if (mph == 1) begin
                    ss  = int'(state_code);
                    sc  = mlast;
                    sv  = int'(score);
                    mph = 2;
                end else if (mph < 18) begin
                    mph++;
                end else begin
                    mrowA = exp_a(ss);
                    mrowB = exp_b(sc, sv);
                    sbq.push_back('{a: mrowA, b: mrowB});
                    m_upd = 1'b1;
                    mph   = 0;
                end
                if (ctrl_code != 8'd0) mlast = int'(ctrl_code);
                mcnt = tk ? 0 : mcnt + 1;
            end
            m_busy = (mph != 0);
        end
    end

    // Monitor: per-cycle handshake checks and scoreboard pops on update
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            chk("update", {127'd0, update}, {127'd0, m_upd});
            chk("busy", {127'd0, busy}, {127'd0, m_busy});
            if (update) begin
                upd_cnt++;
                nvec++;
                if (prev_upd) begin
                    nerr++;
                    $display("FAIL update_width: got 2+ cycle pulse expected 1 cycle");
                end
                nvec++;
                if (sbq.size() == 0) begin
                    nerr++;
                    $display("FAIL sb_empty: got update expected none pending");
                end else begin
                    e = sbq.pop_front();
                    chk("sb_row_A", row_A, e.a);
                    chk("sb_row_B", row_B, e.b);
                end
            end else begin
                chk("hold_row_A", row_A, mrowA);
                chk("hold_row_B", row_B, mrowB);
            end
            prev_upd = update;
        end
    end

    // Random input driver for the soak phase
    initial begin
        forever begin
            @(negedge clk);
            if (rnd_on) begin
                state_code = 8'($urandom);
                score      = 16'($urandom);
                ctrl_code  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            end
        end
    end

    initial begin
        logic [127:0] lit;
        int n;
        reset = 1'b1; state_code = '0; ctrl_code = '0; score = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_row_A", row_A, INIT_ROW);
        chk("rst_row_B", row_B, INIT_ROW);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_update", {127'd0, update}, 128'd0);

        // release with first directed vector; one-cycle ctrl pulse
        reset = 1'b0; state_code = 8'h1A; ctrl_code = 8'h03; score = 16'd12345;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        ctrl_code = 8'h00;
        while (!update && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("first_upd_latency", 128'(n), 128'd50);
        lit = "S:1A  TETRIS    ";
        chk("v1_row_A", row_A, lit);
        lit = "C:03 SCORE 12345";
        chk("v1_row_B", row_B, lit);

        score = 16'd65535;
        wait_upd("v2");
        lit = "C:03 SCORE 65535";
        chk("v2_row_B", row_B, lit);

        score = 16'd0;
        wait_upd("v3");
`ifdef LCD_FMT_ZERO_SUPPRESS_EN
        lit = "C:03 SCORE     0";
`else
        lit = "C:03 SCORE 00000";
`endif
        chk("v3_row_B", row_B, lit);

        // score changes while CONVERT is running
        score = 16'd100;
        wait_busy("v4_busy");
        repeat (4) @(negedge clk);
        score = 16'd999;
        wait_upd("v4");
`ifdef LCD_FMT_ZERO_SUPPRESS_EN
        lit = "C:03 SCORE   100";
`else
        lit = "C:03 SCORE 00100";
`endif
        chk("v4_row_B", row_B, lit);
        wait_upd("v5");
`ifdef LCD_FMT_ZERO_SUPPRESS_EN
        lit = "C:03 SCORE   999";
`else
        lit = "C:03 SCORE 00999";
`endif
        chk("v5_row_B", row_B, lit);

        // reset at tick+10 aborts the refresh
        score = 16'd4242;
        wait_busy("v6_busy");
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_row_A", row_A, INIT_ROW);
        chk("abort_row_B", row_B, INIT_ROW);
        chk("abort_busy", {127'd0, busy}, 128'd0);
        chk("abort_update", {127'd0, update}, 128'd0);
        reset = 1'b0;
        wait_upd("v7");
        lit = "C:00 SCORE 04242";
`ifdef LCD_FMT_ZERO_SUPPRESS_EN
        lit = "C:00 SCORE  4242";
`endif
        chk("v7_row_B", row_B, lit);

        // randomized soak over 200 refreshes
        m_ticks = 0;
        upd_cnt = 0;
        rnd_on  = 1'b1;
        for (int k = 0; k < 200; k++) wait_upd("rnd");
        rnd_on = 1'b0;
        chk("tick_count", 128'(m_ticks), 128'd200);
        chk("upd_count", 128'(upd_cnt), 128'(m_ticks));

        repeat (5) @(negedge clk);
        chk("sb_drained", 128'(sbq.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
